// File: rtl/adder_scoreboard_pkg.sv
// Shared definitions for the adder result scoreboard.
// Provides the FSM state encoding and the bit positions inside the 4-bit
// mismatch / err_flags vector. File-driven benches and loggers import this
// package so that they decode flags the same way the hardware does.
package adder_scoreboard_pkg;

  // Scoreboard run state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Mismatch vector layout: {gen, prop, cout, sum}
  localparam int unsigned MM_SUM  = 0;
  localparam int unsigned MM_COUT = 1;
  localparam int unsigned MM_PROP = 2;
  localparam int unsigned MM_GEN  = 3;
  localparam int unsigned MM_W    = 4;

endpackage : adder_scoreboard_pkg

// File: rtl/adder_scoreboard_if.sv
// Bus between a vector source (adder DUV + reference model + run control)
// and the scoreboard.
//   master : drives run control, operands, reference and DUV results;
//            observes the verdict.
//   slave  : the scoreboard; consumes vectors, drives verdict and capture.
// Parameters: n = operand/sum width, cnt_w = counter width.
interface adder_scoreboard_if #(
  parameter int unsigned n     = 32,
  parameter int unsigned cnt_w = 16
);
  // Run control
  logic             start;
  logic [cnt_w-1:0] num_vec;
  // Vector under check
  logic             valid;
  logic             cin;
  logic [n-1:0]     a;
  logic [n-1:0]     b;
  logic [n-1:0]     s_ref;
  logic [n-1:0]     s_duv;
  logic             cout_ref;
  logic             cout_duv;
  logic             prop_ref;
  logic             prop_duv;
  logic             gen_ref;
  logic             gen_duv;
  // Verdict
  logic             busy;
  logic             done;
  logic             pass;
  logic [cnt_w-1:0] vec_count;
  logic [cnt_w-1:0] err_count;
  logic [3:0]       err_flags;
  // First failing vector
  logic [cnt_w-1:0] first_err_idx;
  logic [n-1:0]     first_err_a;
  logic [n-1:0]     first_err_b;
  logic             first_err_cin;

  modport master (
    output start, num_vec, valid, cin, a, b,
           s_ref, s_duv, cout_ref, cout_duv,
           prop_ref, prop_duv, gen_ref, gen_duv,
    input  busy, done, pass, vec_count, err_count, err_flags,
           first_err_idx, first_err_a, first_err_b, first_err_cin
  );

  modport slave (
    input  start, num_vec, valid, cin, a, b,
           s_ref, s_duv, cout_ref, cout_duv,
           prop_ref, prop_duv, gen_ref, gen_duv,
    output busy, done, pass, vec_count, err_count, err_flags,
           first_err_idx, first_err_a, first_err_b, first_err_cin
  );
endinterface : adder_scoreboard_if

// File: rtl/adder_mismatch.sv
// Combinational compare of DUV against reference adder outputs.
// Ports:
//   s_ref/s_duv       : n-bit sums
//   cout_ref/cout_duv : carry-outs
//   prop_*/gen_*      : group propagate/generate
//   mismatch_c        : {gen, prop, cout, sum} mismatch bits
// cmp_type = 0 : only sum/cout are compared (csa, cra, a1csa)
// cmp_type = 1 : prop/gen also compared (cla, a1csah)
module adder_mismatch
  import adder_scoreboard_pkg::*;
#(
  parameter int unsigned n        = 32,
  parameter bit          cmp_type = 1'b1
) (
  input  logic [n-1:0]    s_ref,
  input  logic [n-1:0]    s_duv,
  input  logic            cout_ref,
  input  logic            cout_duv,
  input  logic            prop_ref,
  input  logic            prop_duv,
  input  logic            gen_ref,
  input  logic            gen_duv,
  output logic [MM_W-1:0] mismatch_c
);

  // Prop/gen differences are masked when the adder family has no group outputs
  always_comb begin
    mismatch_c          = '0;
    mismatch_c[MM_SUM]  = (s_ref != s_duv);
    mismatch_c[MM_COUT] = (cout_ref != cout_duv);
    mismatch_c[MM_PROP] = cmp_type && (prop_ref != prop_duv);
    mismatch_c[MM_GEN]  = cmp_type && (gen_ref != gen_duv);
  end

endmodule : adder_mismatch

// File: rtl/adder_scoreboard.sv
// Self-contained pass/fail checker placed after an adder DUV and its
// reference model. Counts checked and failing vectors, keeps a sticky OR of
// mismatch kinds, captures the first failing vector, and reports done/pass
// once the programmed number of vectors has been checked.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : adder_scoreboard_if slave (run control, vector, verdict)
// Parameters:
//   n        : operand/sum width
//   cmp_type : 0 = sum/cout only, 1 = also prop/gen
//   cnt_w    : width of vector/error counters
module adder_scoreboard
  import adder_scoreboard_pkg::*;
#(
  parameter int unsigned n        = 32,
  parameter bit          cmp_type = 1'b1,
  parameter int unsigned cnt_w    = 16
) (
  input  logic               clk,
  input  logic               rst,
  adder_scoreboard_if.slave  bus
);

  localparam logic [cnt_w-1:0] ERR_MAX = '1;

  state_e           state_q, state_d;
  logic [cnt_w-1:0] num_q, num_d;
  logic [cnt_w-1:0] vec_q, vec_d;
  logic [cnt_w-1:0] err_q, err_d;
  logic [MM_W-1:0]  flags_q, flags_d;
  logic [cnt_w-1:0] idx_q, idx_d;
  logic [n-1:0]     fa_q, fa_d;
  logic [n-1:0]     fb_q, fb_d;
  logic             fcin_q, fcin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [MM_W-1:0]  mismatch_c;
  logic             fail_c;

  adder_mismatch #(
    .n        (n),
    .cmp_type (cmp_type)
  ) u_mismatch (
    .s_ref      (bus.s_ref),
    .s_duv      (bus.s_duv),
    .cout_ref   (bus.cout_ref),
    .cout_duv   (bus.cout_duv),
    .prop_ref   (bus.prop_ref),
    .prop_duv   (bus.prop_duv),
    .gen_ref    (bus.gen_ref),
    .gen_duv    (bus.gen_duv),
    .mismatch_c (mismatch_c)
  );

  assign fail_c = |mismatch_c;

  // Next-state, counter, capture and verdict logic
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    vec_d   = vec_q;
    err_d   = err_q;
    flags_d = flags_q;
    idx_d   = idx_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fcin_d  = fcin_q;

    case (state_q)
      IDLE, DONE: ;
      RUN: begin
        if (bus.valid) begin
          vec_d   = vec_q + cnt_w'(1);
          flags_d = flags_q | mismatch_c;
          if (fail_c) begin
            if (err_q != ERR_MAX) err_d = err_q + cnt_w'(1);
            // A zero error count means this is the first failure of the run
            if (err_q == '0) begin
              idx_d  = vec_q;
              fa_d   = bus.a;
              fb_d   = bus.b;
              fcin_d = bus.cin;
            end
          end
          if (vec_d == num_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // start wins over any vector presented in the same cycle
    if (bus.start) begin
      num_d   = bus.num_vec;
      vec_d   = '0;
      err_d   = '0;
      flags_d = '0;
      idx_d   = '0;
      fa_d    = '0;
      fb_d    = '0;
      fcin_d  = 1'b0;
      state_d = (bus.num_vec == '0) ? DONE : RUN;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      flags_q <= '0;
      idx_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      fcin_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      flags_q <= flags_d;
      idx_q   <= idx_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fcin_q  <= fcin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.vec_count     = vec_q;
  assign bus.err_count     = err_q;
  assign bus.err_flags     = flags_q;
  assign bus.first_err_idx = idx_q;
  assign bus.first_err_a   = fa_q;
  assign bus.first_err_b   = fb_q;
  assign bus.first_err_cin = fcin_q;

endmodule : adder_scoreboard

// File: tb/tb_adder_scoreboard.sv
// Bench for adder_scoreboard: three instances share one directed stimulus
// stream (cmp_type=1/cnt_w=16, cmp_type=0/cnt_w=16, cmp_type=1/cnt_w=4).
// A run-level model per instance predicts every output each cycle; literal
// checks at scenario ends pin the model to hand-derived values.
module tb_adder_scoreboard;

  logic clk;
  logic rst;

  logic        start, valid, cin;
  logic [15:0] num_vec;
  logic [31:0] a, b, s_ref, s_duv;
  logic        cout_ref, cout_duv, prop_ref, prop_duv, gen_ref, gen_duv;

  adder_scoreboard_if #(.n(32), .cnt_w(16)) if1 ();
  adder_scoreboard_if #(.n(32), .cnt_w(16)) if0 ();
  adder_scoreboard_if #(.n(32), .cnt_w(4))  ifs ();

  assign if1.start = start; assign if1.num_vec = num_vec; assign if1.valid = valid;
  assign if1.cin = cin; assign if1.a = a; assign if1.b = b;
  assign if1.s_ref = s_ref; assign if1.s_duv = s_duv;
  assign if1.cout_ref = cout_ref; assign if1.cout_duv = cout_duv;
  assign if1.prop_ref = prop_ref; assign if1.prop_duv = prop_duv;
  assign if1.gen_ref = gen_ref; assign if1.gen_duv = gen_duv;

  assign if0.start = start; assign if0.num_vec = num_vec; assign if0.valid = valid;
  assign if0.cin = cin; assign if0.a = a; assign if0.b = b;
  assign if0.s_ref = s_ref; assign if0.s_duv = s_duv;
  assign if0.cout_ref = cout_ref; assign if0.cout_duv = cout_duv;
  assign if0.prop_ref = prop_ref; assign if0.prop_duv = prop_duv;
  assign if0.gen_ref = gen_ref; assign if0.gen_duv = gen_duv;

  assign ifs.start = start; assign ifs.num_vec = num_vec[3:0]; assign ifs.valid = valid;
  assign ifs.cin = cin; assign ifs.a = a; assign ifs.b = b;
  assign ifs.s_ref = s_ref; assign ifs.s_duv = s_duv;
  assign ifs.cout_ref = cout_ref; assign ifs.cout_duv = cout_duv;
  assign ifs.prop_ref = prop_ref; assign ifs.prop_duv = prop_duv;
  assign ifs.gen_ref = gen_ref; assign ifs.gen_duv = gen_duv;

  adder_scoreboard #(.n(32), .cmp_type(1'b1), .cnt_w(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  adder_scoreboard #(.n(32), .cmp_type(1'b0), .cnt_w(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  adder_scoreboard #(.n(32), .cmp_type(1'b1), .cnt_w(4))  duts (.clk(clk), .rst(rst), .bus(ifs));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Run-level view of a scoreboard: what a verdict must say after each edge
  typedef struct {
    bit          act;
    bit          fin;
    bit          got;
    int unsigned nv;
    int unsigned tgt;
    int unsigned errs;
    int unsigned fidx;
    bit [3:0]    flg;
    logic [31:0] fa;
    logic [31:0] fb;
    bit          fc;
  } mdl_t;

  mdl_t m1, m0, ms;
  int   n_cmp;
  int   n_bad;
  bit   chk_en;

  // fault bits name the injected difference: 0 sum, 1 cout, 2 prop, 3 gen
  function automatic mdl_t step(mdl_t m, bit typ, int unsigned cmax, bit r, bit st,
                                int unsigned num, bit v, logic [31:0] ai, logic [31:0] bi,
                                bit ci, bit [3:0] fault);
    mdl_t     z;
    bit [3:0] seen;
    z = '{default: 0};
    seen = typ ? fault : (fault & 4'b0011);
    if (r) return z;
    if (st) begin
      z.tgt = num % (cmax + 1);
      z.act = (z.tgt != 0);
      z.fin = (z.tgt == 0);
      return z;
    end
    if (m.act && v) begin
      m.nv = m.nv + 1;
      if (seen != 4'b0) begin
        if (!m.got) begin
          m.got  = 1'b1;
          m.fidx = m.nv - 1;
          m.fa   = ai;
          m.fb   = bi;
          m.fc   = ci;
        end
        if (m.errs < cmax) m.errs = m.errs + 1;
      end
      m.flg = m.flg | seen;
      if (m.nv == m.tgt) begin
        m.act = 1'b0;
        m.fin = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all three instances against their models
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("d1.busy", 64'(if1.busy), 64'(m1.act));
      chk("d1.done", 64'(if1.done), 64'(m1.fin));
      chk("d1.pass", 64'(if1.pass), 64'(m1.fin && m1.errs == 0));
      chk("d1.vec", 64'(if1.vec_count), 64'(m1.nv));
      chk("d1.err", 64'(if1.err_count), 64'(m1.errs));
      chk("d1.flags", 64'(if1.err_flags), 64'(m1.flg));
      chk("d1.fidx", 64'(if1.first_err_idx), 64'(m1.fidx));
      chk("d1.fa", 64'(if1.first_err_a), 64'(m1.fa));
      chk("d1.fb", 64'(if1.first_err_b), 64'(m1.fb));
      chk("d1.fcin", 64'(if1.first_err_cin), 64'(m1.fc));
      chk("d0.busy", 64'(if0.busy), 64'(m0.act));
      chk("d0.done", 64'(if0.done), 64'(m0.fin));
      chk("d0.pass", 64'(if0.pass), 64'(m0.fin && m0.errs == 0));
      chk("d0.vec", 64'(if0.vec_count), 64'(m0.nv));
      chk("d0.err", 64'(if0.err_count), 64'(m0.errs));
      chk("d0.flags", 64'(if0.err_flags), 64'(m0.flg));
      chk("d0.fidx", 64'(if0.first_err_idx), 64'(m0.fidx));
      chk("d0.fa", 64'(if0.first_err_a), 64'(m0.fa));
      chk("ds.busy", 64'(ifs.busy), 64'(ms.act));
      chk("ds.done", 64'(ifs.done), 64'(ms.fin));
      chk("ds.pass", 64'(ifs.pass), 64'(ms.fin && ms.errs == 0));
      chk("ds.vec", 64'(ifs.vec_count), 64'(ms.nv));
      chk("ds.err", 64'(ifs.err_count), 64'(ms.errs));
      chk("ds.flags", 64'(ifs.err_flags), 64'(ms.flg));
      chk("ds.fidx", 64'(ifs.first_err_idx), 64'(ms.fidx));
      chk("ds.fb", 64'(ifs.first_err_b), 64'(ms.fb));
      chk("ds.fcin", 64'(ifs.first_err_cin), 64'(ms.fc));
    end
  end

  // One cycle of stimulus, applied on the falling edge
  task automatic cyc(input bit r, input bit st, input int unsigned nv, input bit v,
                     input logic [31:0] ai, input logic [31:0] bi, input bit ci,
                     input bit [3:0] fault);
    logic [32:0] full;
    logic [32:0] nocin;
    @(negedge clk);
    full  = 33'(ai) + 33'(bi) + 33'(ci);
    nocin = 33'(ai) + 33'(bi);
    rst      = r;
    start    = st;
    num_vec  = 16'(nv);
    valid    = v;
    a        = ai;
    b        = bi;
    cin      = ci;
    s_ref    = full[31:0];
    cout_ref = full[32];
    prop_ref = &(ai ^ bi);
    gen_ref  = nocin[32];
    s_duv    = s_ref ^ {31'b0, fault[0]};
    cout_duv = cout_ref ^ fault[1];
    prop_duv = prop_ref ^ fault[2];
    gen_duv  = gen_ref ^ fault[3];
    m1 = step(m1, 1'b1, 65535, r, st, nv, v, ai, bi, ci, fault);
    m0 = step(m0, 1'b0, 65535, r, st, nv, v, ai, bi, ci, fault);
    ms = step(ms, 1'b1, 15, r, st, nv, v, ai, bi, ci, fault);
  endtask

  task automatic go(input int unsigned nv);
    cyc(1'b0, 1'b1, nv, 1'b0, 32'h0, 32'h0, 1'b0, 4'b0);
  endtask

  task automatic vec(input logic [31:0] ai, input logic [31:0] bi, input bit ci,
                     input bit [3:0] fault);
    cyc(1'b0, 1'b0, 0, 1'b1, ai, bi, ci, fault);
  endtask

  task automatic gap();
    cyc(1'b0, 1'b0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 4'b0);
  endtask

  // Let the edge and the per-cycle compare pass before literal checks
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m1 = '{default: 0}; m0 = '{default: 0}; ms = '{default: 0};
    rst = 1'b1; start = 1'b0; num_vec = '0; valid = 1'b0; cin = 1'b0;
    a = '0; b = '0; s_ref = '0; s_duv = '0;
    cout_ref = 1'b0; cout_duv = 1'b0; prop_ref = 1'b0; prop_duv = 1'b0;
    gen_ref = 1'b0; gen_duv = 1'b0;
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 4'b0);
    gap();
    settle();
    chk("lit.rst_done", 64'(if1.done), 64'd0);
    chk("lit.rst_busy", 64'(if1.busy), 64'd0);

    // Clean run, four matching vectors
    go(4);
    vec(32'h0000_0001, 32'h0000_0002, 1'b0, 4'b0);
    vec(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 4'b0);
    vec(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'b0);
    vec(32'h8000_0000, 32'h8000_0000, 1'b0, 4'b0);
    settle();
    chk("lit.clean_done", 64'(if1.done), 64'd1);
    chk("lit.clean_pass", 64'(if1.pass), 64'd1);
    chk("lit.clean_vec", 64'(if1.vec_count), 64'd4);
    chk("lit.clean_err", 64'(if1.err_count), 64'd0);
    chk("lit.clean_flags", 64'(if1.err_flags), 64'd0);
    chk("lit.clean_busy", 64'(if1.busy), 64'd0);

    // Single sum error on vector 2
    go(4);
    vec(32'h0000_0010, 32'h0000_0020, 1'b0, 4'b0);
    vec(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 4'b0);
    vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'b0001);
    vec(32'h0000_0003, 32'h0000_0004, 1'b1, 4'b0);
    settle();
    chk("lit.sum_err", 64'(if1.err_count), 64'd1);
    chk("lit.sum_flags", 64'(if1.err_flags), 64'h1);
    chk("lit.sum_idx", 64'(if1.first_err_idx), 64'd2);
    chk("lit.sum_a", 64'(if1.first_err_a), 64'hFFFF_FFFF);
    chk("lit.sum_b", 64'(if1.first_err_b), 64'h1);
    chk("lit.sum_pass", 64'(if1.pass), 64'd0);
    chk("lit.sum_done", 64'(if1.done), 64'd1);

    // Propagate mismatch on every vector: masked for cmp_type=0 only
    go(3);
    vec(32'h1111_1111, 32'h2222_2222, 1'b0, 4'b0100);
    vec(32'h3333_3333, 32'h4444_4444, 1'b1, 4'b0100);
    vec(32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 4'b0100);
    settle();
    chk("lit.mask_t0_pass", 64'(if0.pass), 64'd1);
    chk("lit.mask_t0_err", 64'(if0.err_count), 64'd0);
    chk("lit.mask_t1_flags", 64'(if1.err_flags), 64'h4);
    chk("lit.mask_t1_err", 64'(if1.err_count), 64'd3);
    chk("lit.mask_t1_cin", 64'(if1.first_err_cin), 64'd0);

    // Gapped valid 1,0,0,1,1 with three vectors programmed
    go(3);
    vec(32'h0000_00AA, 32'h0000_0055, 1'b0, 4'b0);
    gap();
    gap();
    vec(32'h0000_1000, 32'h0000_2000, 1'b1, 4'b0);
    settle();
    chk("lit.gap_vec_mid", 64'(if1.vec_count), 64'd2);
    chk("lit.gap_done_mid", 64'(if1.done), 64'd0);
    vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'b0);
    settle();
    chk("lit.gap_done", 64'(if1.done), 64'd1);
    chk("lit.gap_vec", 64'(if1.vec_count), 64'd3);

    // Fifteen failing vectors on the 4-bit-counter instance, then an empty run
    go(15);
    for (int i = 0; i < 15; i++)
      vec(32'(i * 7 + 1), 32'(i * 3), i[0], 4'b0001);
    settle();
    chk("lit.sat_err", 64'(ifs.err_count), 64'd15);
    chk("lit.sat_vec", 64'(ifs.vec_count), 64'd15);
    chk("lit.sat_idx", 64'(ifs.first_err_idx), 64'd0);
    chk("lit.sat_a", 64'(ifs.first_err_a), 64'd1);
    go(0);
    settle();
    chk("lit.zero_done", 64'(ifs.done), 64'd1);
    chk("lit.zero_pass", 64'(ifs.pass), 64'd1);
    chk("lit.zero_err", 64'(ifs.err_count), 64'd0);

    // Restart after two checked vectors; the start-cycle vector is ignored
    go(5);
    vec(32'h0000_0100, 32'h0000_0200, 1'b0, 4'b0010);
    vec(32'h0000_0300, 32'h0000_0400, 1'b0, 4'b1000);
    cyc(1'b0, 1'b1, 2, 1'b1, 32'hABCD_0000, 32'h0000_EF01, 1'b1, 4'b0001);
    settle();
    chk("lit.rs_vec", 64'(if1.vec_count), 64'd0);
    chk("lit.rs_err", 64'(if1.err_count), 64'd0);
    chk("lit.rs_flags", 64'(if1.err_flags), 64'd0);
    chk("lit.rs_busy", 64'(if1.busy), 64'd1);
    vec(32'h0000_0005, 32'h0000_0006, 1'b0, 4'b0);
    vec(32'h0000_0007, 32'h0000_0008, 1'b1, 4'b0);
    settle();
    chk("lit.rs_done", 64'(if1.done), 64'd1);
    chk("lit.rs_pass", 64'(if1.pass), 64'd1);
    chk("lit.rs_vec2", 64'(if1.vec_count), 64'd2);

    // Reset in the middle of a failing run
    go(4);
    vec(32'h0000_0009, 32'h0000_000A, 1'b1, 4'b0001);
    vec(32'h0000_000B, 32'h0000_000C, 1'b0, 4'b0001);
    cyc(1'b1, 1'b0, 0, 1'b1, 32'h0000_000D, 32'h0000_000E, 1'b0, 4'b0001);
    settle();
    chk("lit.rst_mid_busy", 64'(if1.busy), 64'd0);
    chk("lit.rst_mid_vec", 64'(if1.vec_count), 64'd0);
    chk("lit.rst_mid_err", 64'(if1.err_count), 64'd0);
    chk("lit.rst_mid_fa", 64'(if1.first_err_a), 64'd0);
    gap();
    gap();
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_adder_scoreboard
